// File: rtl/div_ctrl.sv
// -----------------------------------------------------------------------------
// div_ctrl
//
// Sequencing controller for the shared multi-cycle radix-2 divider in EX.
// Accepts DIV/DIVU requests, latches the operands and holds them stable for the
// whole operation. Drives the divider start/annul handshake and requests a
// pipeline stall while the divide runs. Presents the {HI, LO} result for
// exactly one accepted pipeline advance. Cancels an in-flight divide on a
// pipeline flush.
//
// Optional feature macro:
//   DIV_CTRL_FASTPATH_EN  - divisors 0 and 1 bypass the divider. The result is
//                           valid one cycle after acceptance. Without the
//                           macro, every divisor goes through the divider.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   req_i         EX holds a DIV/DIVU instruction
//   signed_i      1 = DIV, 0 = DIVU
//   op1_i/op2_i   dividend / divisor
//   flush_i       pipeline flush (squash in-flight divide)
//   hold_i        later-stage stall; EX cannot advance this cycle
//   div_start_o   divider start (registered)
//   div_annul_o   divider annul (registered)
//   div_signed_o  latched signedness to the divider
//   div_op1_o     latched dividend to the divider
//   div_op2_o     latched divisor to the divider
//   div_result_i  divider result: [63:32] remainder, [31:0] quotient
//   div_ready_i   divider result-ready
//   stallreq_o    stall EX and earlier stages (combinational)
//   valid_o       hi_o/lo_o valid; HI/LO write enable
//   hi_o, lo_o    remainder / quotient
// -----------------------------------------------------------------------------
module div_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        signed_i,
    input  logic [31:0] op1_i,
    input  logic [31:0] op2_i,
    input  logic        flush_i,
    input  logic        hold_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        stallreq_o,
    output logic        valid_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic accept;   // request taken this cycle (meaningful in IDLE only)
    logic fast;     // accepted request resolved without the divider

    always_comb begin
        accept = (state == IDLE) && req_i && !flush_i;
    end

`ifdef DIV_CTRL_FASTPATH_EN
    always_comb begin
        fast = accept && (op2_i[31:1] == '0);
    end
`else
    always_comb begin
        fast = 1'b0;
    end
`endif

    // ---------------------------------------------------------------------
    // State register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = fast ? DONE : BUSY;
                end
            end
            BUSY: begin
                // Flush wins over a result arriving in the same cycle.
                if (flush_i) begin
                    state_next = FLUSH;
                end else if (div_ready_i) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // req_i is the same instruction here and is ignored.
                if (!hold_i || flush_i) begin
                    state_next = IDLE;
                end
            end
            FLUSH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Combinational outputs
    // ---------------------------------------------------------------------
    always_comb begin
        stallreq_o = 1'b0;
        unique case (state)
            IDLE:    stallreq_o = accept;
            BUSY:    stallreq_o = 1'b1;
            default: stallreq_o = 1'b0;
        endcase
    end

    // ---------------------------------------------------------------------
    // Registered outputs and datapath
    // Handshake flags are registered from the next state. This keeps them
    // glitch-free and aligned with the state they describe.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            div_start_o  <= 1'b0;
            div_annul_o  <= 1'b0;
            valid_o      <= 1'b0;
            div_signed_o <= 1'b0;
            div_op1_o    <= '0;
            div_op2_o    <= '0;
            hi_o         <= '0;
            lo_o         <= '0;
        end else begin
            div_start_o <= (state_next == BUSY);
            div_annul_o <= (state_next == FLUSH);
            valid_o     <= (state_next == DONE);

            // The divider re-reads the operands at sign fix-up. They change
            // only when a new request is accepted.
            if (accept) begin
                div_signed_o <= signed_i;
                div_op1_o    <= op1_i;
                div_op2_o    <= op2_i;
            end

            if (fast) begin
                hi_o <= '0;
                lo_o <= op2_i[0] ? op1_i : '0;
            end else if ((state == BUSY) && !flush_i && div_ready_i) begin
                hi_o <= div_result_i[63:32];
                lo_o <= div_result_i[31:0];
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        sgn;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic        hold;
    logic        div_start;
    logic        div_annul;
    logic        div_signed;
    logic [31:0] dop1;
    logic [31:0] dop2;
    logic [63:0] dres;
    logic        dready;
    logic        stall;
    logic        valid;
    logic [31:0] hi;
    logic [31:0] lo;

    div_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .req_i        (req),
        .signed_i     (sgn),
        .op1_i        (op1),
        .op2_i        (op2),
        .flush_i      (flush),
        .hold_i       (hold),
        .div_start_o  (div_start),
        .div_annul_o  (div_annul),
        .div_signed_o (div_signed),
        .div_op1_o    (dop1),
        .div_op2_o    (dop2),
        .div_result_i (dres),
        .div_ready_i  (dready),
        .stallreq_o   (stall),
        .valid_o      (valid),
        .hi_o         (hi),
        .lo_o         (lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Divider model: ready rises 35 start-cycles after start, result held
    // until start drops; annul or start low clears it.
    // ------------------------------------------------------------------
    function automatic logic [63:0] model_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (b == 32'd0) begin
            q = '0;
            r = '0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    int          dcnt = 0;
    logic        mready = 1'b0;
    logic [63:0] mres = '0;
    logic        spurious = 1'b0;

    always @(posedge clk) begin
        if (!div_start || div_annul) begin
            dcnt   <= 0;
            mready <= 1'b0;
        end else begin
            dcnt <= dcnt + 1;
            if (dcnt == 34) begin
                mready <= 1'b1;
                mres   <= model_div(div_signed, dop1, dop2);
            end
        end
    end

    assign dready = mready | spurious;
    assign dres   = mres;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          t;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    logic        pv = 1'b0;
    logic [31:0] phi = '0;
    logic [31:0] plo = '0;

    always @(negedge clk) begin
        if (valid && !pv) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 64'(valid), 64'd0);
            end else begin
                mon_e = sb.pop_front();
                check("result_hi", 64'(hi), 64'(mon_e.hi));
                check("result_lo", 64'(lo), 64'(mon_e.lo));
                check("result_latency", 64'(cyc - mon_e.t), 64'(mon_e.lat));
            end
        end else if (valid && pv) begin
            check("hold_hi_stable", 64'(hi), 64'(phi));
            check("hold_lo_stable", 64'(lo), 64'(plo));
            check("hold_no_restart", 64'(div_start), 64'd0);
        end
        pv  <= valid;
        phi <= hi;
        plo <= lo;
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo, input int hold_n);
        int   t;
        int   lat;
        int   bad_stall = 0;
        int   bad_ops = 0;
        int   first_start = -1;
        int   waited = 0;
        exp_t e;
`ifdef DIV_CTRL_FASTPATH_EN
        lat = (b <= 32'd1) ? 1 : 37;
`else
        lat = 37;
`endif
        @(posedge clk);
        #1;
        t   = cyc;
        req = 1'b1;
        sgn = s;
        op1 = a;
        op2 = b;
        e.hi = ehi;
        e.lo = elo;
        e.t = t;
        e.lat = lat;
        sb.push_back(e);
        @(negedge clk);
        while (!valid && waited < 100) begin
            if (!stall) bad_stall++;
            if (div_start) begin
                if (first_start < 0) first_start = cyc - t;
                if (dop1 !== a || dop2 !== b || div_signed !== s) bad_ops++;
            end
            waited++;
            @(negedge clk);
        end
        check("result_timeout", 64'(waited >= 100), 64'd0);
        check("stall_window", 64'(bad_stall), 64'd0);
        check("ops_stable", 64'(bad_ops), 64'd0);
        check("start_cycle", 64'(first_start), (lat == 1) ? 64'(-1) : 64'd1);
        check("stall_at_valid", 64'(stall), 64'd0);
        hold = (hold_n > 0);
        repeat (hold_n) @(negedge clk);
        hold = 1'b0;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        check("valid_drop", 64'(valid), 64'd0);
    endtask

    // Starts a divide and kills it after 'at' cycles via flush or reset.
    task automatic run_abort(input bit use_rst, input int at, input logic s,
                             input logic [31:0] a, input logic [31:0] b);
        @(posedge clk);
        #1;
        req = 1'b1;
        sgn = s;
        op1 = a;
        op2 = b;
        repeat (at) @(posedge clk);
        #1;
        req = 1'b0;
        if (use_rst) rst = 1'b1;
        else         flush = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        flush = 1'b0;
        if (!use_rst) req = 1'b1;   // must not be accepted while in FLUSH
        @(negedge clk);
        if (use_rst) begin
            check("rst_ctrl_zero", 64'({div_start, div_annul, div_signed, valid, stall}), 64'd0);
            check("rst_ops_zero", {dop1, dop2}, 64'd0);
            check("rst_hilo_zero", {hi, lo}, 64'd0);
        end else begin
            check("flush_annul", 64'(div_annul), 64'd1);
            check("flush_start_low", 64'(div_start), 64'd0);
            check("flush_stall_low", 64'(stall), 64'd0);
        end
        @(posedge clk);
        #1;
        req = 1'b0;
        @(negedge clk);
        check("abort_idle_handshake", 64'({div_start, div_annul}), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        req = 1'b0;
        sgn = 1'b0;
        op1 = '0;
        op2 = '0;
        flush = 1'b0;
        hold = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", 64'({div_start, div_annul, div_signed, valid, stall}), 64'd0);
        check("reset_ops", {dop1, dop2}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        rst = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 0);
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
        run_div(1'b0, 32'd1000, 32'd10, 32'd0, 32'd100, 3);

        run_abort(1'b0, 10, 1'b0, 32'd123456, 32'd789);
        run_div(1'b0, 32'd9, 32'd3, 32'd0, 32'd3, 0);

        run_div(1'b0, 32'd1234, 32'd0, 32'd0, 32'd0, 0);
        run_div(1'b0, 32'hDEAD_BEEF, 32'd1, 32'd0, 32'hDEAD_BEEF, 0);

        // Ready outside BUSY must be ignored.
        @(posedge clk);
        #1;
        spurious = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        spurious = 1'b0;
        @(negedge clk);
        check("spurious_ready_ignored", 64'({valid, div_start, stall}), 64'd0);

        run_abort(1'b1, 20, 1'b1, 32'd77777, 32'hFFFF_FFFD);
        run_div(1'b0, 32'd50, 32'd5, 32'd0, 32'd10, 0);

        run_div(1'b1, 32'h8000_0000, 32'd1, 32'd0, 32'h8000_0000, 2);
        run_div(1'b0, 32'd7, 32'd7, 32'd0, 32'd1, 0);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

endmodule
